// File: rtl/elevador_pkg.sv
// ---------------------------------------------------------------------------
// elevador_pkg
// Shared definitions for the elevator call scheduler:
//   - N_FLOORS / FLOOR_W : floor count and floor index width
//   - state_t            : scheduler state encoding (IDLE, DISPATCH, DOOR)
//   - onehot()           : floor index to one-hot floor mask; indices at or
//                          above N_FLOORS map to an all-zero mask
// ---------------------------------------------------------------------------
package elevador_pkg;

    localparam int N_FLOORS = 5;
    localparam int FLOOR_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPATCH = 2'b01,
        DOOR     = 2'b10
    } state_t;

    // An out-of-range floor matches no bit, so it can never select or clear
    // a pending call.
    function automatic logic [N_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] idx);
        logic [N_FLOORS-1:0] mask;
        mask = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (idx == FLOOR_W'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_select.sv
// ---------------------------------------------------------------------------
// scan_select
// Combinational SCAN target picker.
// Ports:
//   i_pending     : latched calls, bit i = floor i
//   i_andar_atual : current car floor
//   i_dir_up      : current sweep direction (1 = up)
//   o_target      : chosen floor
//   o_found       : a call exists away from the current floor
//   o_flip_dir    : target lies against the current sweep direction
// ---------------------------------------------------------------------------
module scan_select
    import elevador_pkg::*;
(
    input  logic [N_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]  i_andar_atual,
    input  logic                i_dir_up,
    output logic [FLOOR_W-1:0]  o_target,
    output logic                o_found,
    output logic                o_flip_dir
);

    logic [FLOOR_W-1:0] w_up_tgt;
    logic [FLOOR_W-1:0] w_dn_tgt;
    logic               w_up_found;
    logic               w_dn_found;

    // Scan upward floors from the top down so the last hit is the nearest
    // call above; scan downward floors from the bottom up so the last hit
    // is the nearest call below.
    always_comb begin
        w_up_tgt   = '0;
        w_up_found = 1'b0;
        w_dn_tgt   = '0;
        w_dn_found = 1'b0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (FLOOR_W'(i) > i_andar_atual)) begin
                w_up_tgt   = FLOOR_W'(i);
                w_up_found = 1'b1;
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i_pending[i] && (FLOOR_W'(i) < i_andar_atual)) begin
                w_dn_tgt   = FLOOR_W'(i);
                w_dn_found = 1'b1;
            end
        end
    end

    // Keep sweeping in the current direction while calls remain that way;
    // otherwise reverse and take the nearest call on the other side.
    always_comb begin
        o_target   = '0;
        o_found    = 1'b0;
        o_flip_dir = 1'b0;
        if (i_dir_up) begin
            if (w_up_found) begin
                o_target = w_up_tgt;
                o_found  = 1'b1;
            end else if (w_dn_found) begin
                o_target   = w_dn_tgt;
                o_found    = 1'b1;
                o_flip_dir = 1'b1;
            end
        end else begin
            if (w_dn_found) begin
                o_target = w_dn_tgt;
                o_found  = 1'b1;
            end else if (w_up_found) begin
                o_target   = w_up_tgt;
                o_found    = 1'b1;
                o_flip_dir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevador_chamadas.sv
// ---------------------------------------------------------------------------
// elevador_chamadas
// Call scheduler placed in front of the elevator car controller. Latches
// floor-call buttons, picks the next target with a SCAN policy, holds a
// one-hot request until the car stops at the target, then runs a door dwell.
// Ports:
//   i_clk          : system clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_btn          : call buttons, level sampled each cycle
//   i_andar_atual  : current floor from the car controller
//   i_motor_up     : car controller up-motor output
//   i_motor_down   : car controller down-motor output
//   o_req          : one-hot request to the car controller (0 = none)
//   o_pending      : latched, unserved calls
//   o_door_open    : door dwell active
//   o_dir_up       : SCAN direction (1 = up)
//   o_busy         : state is not IDLE
// ---------------------------------------------------------------------------
module elevador_chamadas
    import elevador_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_FLOORS-1:0] i_btn,
    input  logic [FLOOR_W-1:0]  i_andar_atual,
    input  logic                i_motor_up,
    input  logic                i_motor_down,
    output logic [N_FLOORS-1:0] o_req,
    output logic [N_FLOORS-1:0] o_pending,
    output logic                o_door_open,
    output logic                o_dir_up,
    output logic                o_busy
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);

    state_t              r_state;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] r_req;
    logic [FLOOR_W-1:0]  r_target;
    logic                r_dir_up;
    logic [CNT_W-1:0]    r_cnt;

    state_t              w_next_state;
    logic [N_FLOORS-1:0] w_pending_next;
    logic [N_FLOORS-1:0] w_req_next;
    logic [FLOOR_W-1:0]  w_target_next;
    logic                w_dir_next;
    logic [CNT_W-1:0]    w_cnt_next;

    logic [N_FLOORS-1:0] w_here;
    logic [N_FLOORS-1:0] w_set_mask;
    logic [N_FLOORS-1:0] w_clr;
    logic                w_arrive;
    logic [FLOOR_W-1:0]  w_scan_target;
    logic                w_scan_found;
    logic                w_scan_flip;

    scan_select u_scan (
        .i_pending     (r_pending),
        .i_andar_atual (i_andar_atual),
        .i_dir_up      (r_dir_up),
        .o_target      (w_scan_target),
        .o_found       (w_scan_found),
        .o_flip_dir    (w_scan_flip)
    );

    // Arrival needs both motors idle: the controller reports the target floor
    // on its last moving cycle too, and that cycle must not open the door.
    assign w_here   = onehot(i_andar_atual);
    assign w_arrive = (r_state == DISPATCH) && (i_andar_atual == r_target) &&
                      !i_motor_up && !i_motor_down;

    // A press at the floor being served is absorbed by the open door instead
    // of becoming a new pending call.
    assign w_set_mask = ((r_state == DOOR) || w_arrive) ? w_here : '0;

    // Next-state and datapath updates; clear takes priority over set on the
    // same pending bit.
    always_comb begin
        w_next_state  = r_state;
        w_req_next    = r_req;
        w_target_next = r_target;
        w_dir_next    = r_dir_up;
        w_cnt_next    = r_cnt;
        w_clr         = '0;

        case (r_state)
            IDLE: begin
                if ((r_pending & w_here) != '0) begin
                    w_next_state = DOOR;
                    w_clr        = w_here;
                    w_cnt_next   = DWELL_LOAD;
                end else if (w_scan_found) begin
                    w_next_state  = DISPATCH;
                    w_target_next = w_scan_target;
                    w_req_next    = onehot(w_scan_target);
                    w_dir_next    = w_scan_flip ? ~r_dir_up : r_dir_up;
                end
            end
            DISPATCH: begin
                if (w_arrive) begin
                    w_next_state = DOOR;
                    w_clr        = onehot(r_target);
                    w_req_next   = '0;
                    w_cnt_next   = DWELL_LOAD;
                end
            end
            DOOR: begin
                if ((i_btn & w_here) != '0) begin
                    w_cnt_next = DWELL_LOAD;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_req_next   = '0;
                w_cnt_next   = '0;
            end
        endcase

        w_pending_next = (r_pending | (i_btn & ~w_set_mask)) & ~w_clr;
    end

    // State and datapath registers; reset drops the request immediately so
    // the car stops where it is.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_req     <= '0;
            r_target  <= '0;
            r_dir_up  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_req     <= w_req_next;
            r_target  <= w_target_next;
            r_dir_up  <= w_dir_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign o_req       = r_req;
    assign o_pending   = r_pending;
    assign o_door_open = (r_state == DOOR);
    assign o_dir_up    = r_dir_up;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_elevador_chamadas.sv
// ---------------------------------------------------------------------------
// tb_elevador_chamadas
// Directed bench for the elevator call scheduler. The bench plays the car
// controller itself by driving floor and motor inputs step by step.
// ---------------------------------------------------------------------------
module tb_elevador_chamadas;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic [2:0] andar;
    logic       motorUp;
    logic       motorDown;
    logic [4:0] req;
    logic [4:0] pending;
    logic       doorOpen;
    logic       dirUp;
    logic       busy;

    int checks;
    int failures;

    elevador_chamadas #(.DWELL_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn         (btn),
        .i_andar_atual (andar),
        .i_motor_up    (motorUp),
        .i_motor_down  (motorDown),
        .o_req         (req),
        .o_pending     (pending),
        .o_door_open   (doorOpen),
        .o_dir_up      (dirUp),
        .o_busy        (busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] b, input logic [2:0] floorIdx,
                                 input logic up, input logic down);
        btn       = b;
        andar     = floorIdx;
        motorUp   = up;
        motorDown = down;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Four-cycle dwell starting right after the arrival edge just taken.
    task automatic checkDwell(input string tag);
        checkOutput({tag, "_door1"}, {7'd0, doorOpen}, 8'd1);
        tick();
        checkOutput({tag, "_door2"}, {7'd0, doorOpen}, 8'd1);
        tick();
        checkOutput({tag, "_door3"}, {7'd0, doorOpen}, 8'd1);
        tick();
        checkOutput({tag, "_door4"}, {7'd0, doorOpen}, 8'd1);
        tick();
        checkOutput({tag, "_doorEnd"}, {7'd0, doorOpen}, 8'd0);
        checkOutput({tag, "_idle"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);

        // Reset state
        #8;
        checkOutput("rst_req", {3'd0, req}, 8'h00);
        checkOutput("rst_pending", {3'd0, pending}, 8'h00);
        checkOutput("rst_door", {7'd0, doorOpen}, 8'd0);
        checkOutput("rst_dir", {7'd0, dirUp}, 8'd1);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;
        tick();

        // 1: single call to floor 3 from floor 0
        $display("[TB] test 1: call to floor 3");
        applyStimulus(5'b01000, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t1_pending", {3'd0, pending}, 8'h08);
        checkOutput("t1_noreqyet", {3'd0, req}, 8'h00);
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t1_req", {3'd0, req}, 8'h08);
        checkOutput("t1_busy", {7'd0, busy}, 8'd1);
        applyStimulus(5'b00000, 3'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'b00000, 3'd2, 1'b1, 1'b0);
        tick();
        applyStimulus(5'b00000, 3'd3, 1'b1, 1'b0);
        tick();
        checkOutput("t1_movingAtTarget", {3'd0, req}, 8'h08);
        applyStimulus(5'b00000, 3'd3, 1'b0, 1'b0);
        tick();
        checkOutput("t1_arriveReq", {3'd0, req}, 8'h00);
        checkOutput("t1_arrivePending", {3'd0, pending}, 8'h00);
        checkDwell("t1");

        // 2: car at 2 heading up, calls at 0 and 4
        $display("[TB] test 2: SCAN ordering");
        applyStimulus(5'b10001, 3'd2, 1'b0, 1'b0);
        tick();
        checkOutput("t2_pending", {3'd0, pending}, 8'h11);
        applyStimulus(5'b00000, 3'd2, 1'b0, 1'b0);
        tick();
        checkOutput("t2_reqUp", {3'd0, req}, 8'h10);
        checkOutput("t2_dirUp", {7'd0, dirUp}, 8'd1);
        applyStimulus(5'b00000, 3'd4, 1'b0, 1'b0);
        tick();
        checkOutput("t2_arrivePending", {3'd0, pending}, 8'h01);
        checkDwell("t2");
        tick();
        checkOutput("t2_reqDown", {3'd0, req}, 8'h01);
        checkOutput("t2_dirDown", {7'd0, dirUp}, 8'd0);
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t2_arrive0", {7'd0, doorOpen}, 8'd1);
        tick();
        tick();
        tick();
        tick();
        checkOutput("t2_idleAt0", {7'd0, busy}, 8'd0);

        // 3: call at current floor, and dwell reload
        $display("[TB] test 3: call at current floor");
        applyStimulus(5'b00001, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_pending", {3'd0, pending}, 8'h01);
        checkOutput("t3_noDoorYet", {7'd0, doorOpen}, 8'd0);
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_door", {7'd0, doorOpen}, 8'd1);
        checkOutput("t3_noReq", {3'd0, req}, 8'h00);
        checkOutput("t3_cleared", {3'd0, pending}, 8'h00);
        tick();
        applyStimulus(5'b00001, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_pressNoPending", {3'd0, pending}, 8'h00);
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("t3_extended", {7'd0, doorOpen}, 8'd1);
        tick();
        checkOutput("t3_end", {7'd0, doorOpen}, 8'd0);
        checkOutput("t3_endPending", {3'd0, pending}, 8'h00);

        // 4 + 5: trip to 4 with a late call to 1, last moving cycle at target
        $display("[TB] test 4/5: no retarget, motor-high arrival");
        applyStimulus(5'b10000, 3'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t4_req", {3'd0, req}, 8'h10);
        checkOutput("t4_dirFlipUp", {7'd0, dirUp}, 8'd1);
        applyStimulus(5'b00000, 3'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'b00010, 3'd2, 1'b1, 1'b0);
        tick();
        checkOutput("t4_latePending", {3'd0, pending}, 8'h12);
        checkOutput("t4_noRetarget", {3'd0, req}, 8'h10);
        applyStimulus(5'b00000, 3'd3, 1'b1, 1'b0);
        tick();
        checkOutput("t4_stillReq", {3'd0, req}, 8'h10);
        applyStimulus(5'b00000, 3'd4, 1'b1, 1'b0);
        tick();
        checkOutput("t5_motorHighNoDoor", {7'd0, doorOpen}, 8'd0);
        checkOutput("t5_motorHighReq", {3'd0, req}, 8'h10);
        applyStimulus(5'b00000, 3'd4, 1'b0, 1'b0);
        tick();
        checkOutput("t5_doorOpens", {7'd0, doorOpen}, 8'd1);
        checkOutput("t5_reqDropped", {3'd0, req}, 8'h00);
        checkOutput("t4_pendingLeft", {3'd0, pending}, 8'h02);
        tick();
        tick();
        tick();
        tick();
        tick();
        checkOutput("t4_reqFloor1", {3'd0, req}, 8'h02);
        checkOutput("t4_dirDown", {7'd0, dirUp}, 8'd0);

        // 6: asynchronous reset in the middle of a trip
        $display("[TB] test 6: async reset mid-dispatch");
        applyStimulus(5'b00000, 3'd3, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_req", {3'd0, req}, 8'h00);
        checkOutput("t6_pending", {3'd0, pending}, 8'h00);
        checkOutput("t6_door", {7'd0, doorOpen}, 8'd0);
        checkOutput("t6_busy", {7'd0, busy}, 8'd0);
        applyStimulus(5'b00000, 3'd3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("t6_dirAfter", {7'd0, dirUp}, 8'd1);
        checkOutput("t6_idleAfter", {7'd0, busy}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
